// File: rtl/decim_pkg.sv
// -----------------------------------------------------------------------------
// decim_pkg
// Shared types and constants for the ADC decimator:
//   - state_e       : decimator FSM states (IDLE, ACCUM)
//   - ratio_t       : {R, K} pair, block length and Q29 reciprocal of R
//   - R_* / K_*     : ratio and scale constant tables
//   - Q29_SHIFT     : binary point of K
//   - ROUND_CONST   : half an LSB of the Q29 result, for round half-up
//   - mode_to_ratio : maps the 3-bit Mode input to its {R, K} pair
// -----------------------------------------------------------------------------
package decim_pkg;

  localparam int CNT_W     = 10;  // holds R-1 up to 999
  localparam int K_W       = 32;
  localparam int PROD_W    = 64;
  localparam int Q29_SHIFT = 29;

  localparam logic signed [PROD_W-1:0] ROUND_CONST = 64'sd268435456;  // 2^28

  typedef enum logic {
    IDLE,
    ACCUM
  } state_e;

  typedef struct packed {
    logic [CNT_W-1:0] r;
    logic [K_W-1:0]   k;
  } ratio_t;

  localparam logic [CNT_W-1:0] R_1    = 10'd1;
  localparam logic [CNT_W-1:0] R_10   = 10'd10;
  localparam logic [CNT_W-1:0] R_100  = 10'd100;
  localparam logic [CNT_W-1:0] R_1000 = 10'd1000;

  // K = round(2^29 / R), identical to the transmit-path interpolator table.
  localparam logic [K_W-1:0] K_1    = 32'd536870912;
  localparam logic [K_W-1:0] K_10   = 32'd53687091;
  localparam logic [K_W-1:0] K_100  = 32'd5368709;
  localparam logic [K_W-1:0] K_1000 = 32'd536871;

  // Modes 4..7 are reserved and fall back to pass-through (R=1).
  function automatic ratio_t mode_to_ratio(input logic [2:0] mode);
    ratio_t rt;
    case (mode)
      3'd1:    rt = '{r: R_10,   k: K_10};
      3'd2:    rt = '{r: R_100,  k: K_100};
      3'd3:    rt = '{r: R_1000, k: K_1000};
      default: rt = '{r: R_1,    k: K_1};
    endcase
    return rt;
  endfunction

endpackage

// File: rtl/decim_scaler.sv
// -----------------------------------------------------------------------------
// decim_scaler
// One registered stage that turns a block sum into a block average:
//   out = (sum * K + 2^28) >>> 29, i.e. bits [60:29] of the rounded product.
// Ports:
//   clk, rst      : clock, asynchronous active-high reset
//   in_sum        : signed block sum
//   in_k          : unsigned Q29 reciprocal of the block length
//   in_valid      : in_sum/in_k carry a finished block this cycle
//   out_data      : signed rounded average (registered)
//   out_valid     : out_data was loaded on the last edge
// -----------------------------------------------------------------------------
module decim_scaler
  import decim_pkg::*;
#(
  parameter int ACC_W = 32
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic signed [ACC_W-1:0] in_sum,
  input  logic        [K_W-1:0]   in_k,
  input  logic                    in_valid,
  output logic signed [ACC_W-1:0] out_data,
  output logic                    out_valid
);

  logic signed [PROD_W-1:0] sum_ext;
  logic signed [PROD_W-1:0] k_ext;
  logic signed [ACC_W-1:0]  data_q, data_d;
  logic                     valid_q, valid_d;

  assign sum_ext = PROD_W'(in_sum);
  // K is unsigned: zero-extend so the multiply treats it as positive.
  assign k_ext   = {{(PROD_W-K_W){1'b0}}, in_k};

  always_comb begin
    data_d  = data_q;
    valid_d = in_valid;
    if (in_valid) begin
      // Arithmetic shift keeps floor semantics, so +2^28 gives round half-up
      // for negative sums too. |sum| <= 2,048,000 keeps the product in range.
      data_d = ACC_W'((sum_ext * k_ext + ROUND_CONST) >>> Q29_SHIFT);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      data_q  <= '0;
      valid_q <= 1'b0;
    end else begin
      data_q  <= data_d;
      valid_q <= valid_d;
    end
  end

  assign out_data  = data_q;
  assign out_valid = valid_q;

endmodule

// File: rtl/adc_decimator.sv
// -----------------------------------------------------------------------------
// adc_decimator
// Converts offset-binary ADC samples to two's complement, sums blocks of
// R = 1/10/100/1000 samples and emits the Q29-scaled block average over a
// valid/ready handshake.
// Ports:
//   Fg_CLK, Fg_RESET : clock, asynchronous active-high reset
//   AdcData/AdcValid : offset-binary sample and its qualifier
//   Mode             : ratio select, latched when a run starts
//   Run              : level; 1 = decimate, 0 = stop and drop partial block
//   OutData/OutValid : block average and its unconsumed flag
//   OutReady         : consumer accepts OutData
//   Busy             : FSM is accumulating
//   Overrun          : sticky, an unconsumed result was overwritten
//   FrameCount       : completed blocks, wrapping
// Latency: last sample of a block at edge k -> sum at k, scaled at k+1,
// OutData/OutValid/FrameCount at k+2.
// -----------------------------------------------------------------------------
module adc_decimator
  import decim_pkg::*;
#(
  parameter int DATA_W = 12,
  parameter int ACC_W  = 32
) (
  input  logic                    Fg_CLK,
  input  logic                    Fg_RESET,
  input  logic [DATA_W-1:0]       AdcData,
  input  logic                    AdcValid,
  input  logic [2:0]              Mode,
  input  logic                    Run,
  output logic signed [ACC_W-1:0] OutData,
  output logic                    OutValid,
  input  logic                    OutReady,
  output logic                    Busy,
  output logic                    Overrun,
  output logic [15:0]             FrameCount
);

  state_e                  state_q, state_d;
  logic signed [ACC_W-1:0] acc_q, acc_d;
  logic [CNT_W-1:0]        count_q, count_d;
  logic [CNT_W-1:0]        r_q, r_d;
  logic [K_W-1:0]          k_q, k_d;
  logic signed [ACC_W-1:0] sum_q, sum_d;
  logic [K_W-1:0]          sum_k_q, sum_k_d;
  logic                    sum_valid_q, sum_valid_d;
  logic signed [ACC_W-1:0] out_data_q, out_data_d;
  logic                    out_valid_q, out_valid_d;
  logic                    overrun_q, overrun_d;
  logic [15:0]             frame_count_q, frame_count_d;

  logic signed [ACC_W-1:0] sample_s;
  logic signed [ACC_W-1:0] scl_data;
  logic                    scl_valid;
  logic                    run_start;
  ratio_t                  mode_ratio;

  // Flipping the MSB turns offset binary into two's complement.
  assign sample_s   = ACC_W'($signed({~AdcData[DATA_W-1], AdcData[DATA_W-2:0]}));
  assign mode_ratio = mode_to_ratio(Mode);
  assign run_start  = (state_q == IDLE) && Run;

  // FSM, accumulator and block counter.
  always_comb begin
    // NOTE: every *_d takes its current value first, so no branch leaves a
    // signal unassigned and no latch is inferred.
    state_d     = state_q;
    acc_d       = acc_q;
    count_d     = count_q;
    r_d         = r_q;
    k_d         = k_q;
    sum_d       = sum_q;
    sum_k_d     = sum_k_q;
    sum_valid_d = 1'b0;

    case (state_q)
      IDLE: begin
        if (Run) begin
          state_d = ACCUM;
          r_d     = mode_ratio.r;
          k_d     = mode_ratio.k;
          acc_d   = '0;
          count_d = '0;
        end
      end
      ACCUM: begin
        if (!Run) begin
          // Run has priority over a sample on the same edge.
          state_d = IDLE;
          acc_d   = '0;
          count_d = '0;
        end else if (AdcValid) begin
          if (count_q == r_q - CNT_W'(1)) begin
            // Hand the finished sum to the scaler and restart on the same
            // edge so a gap-free stream loses nothing. K travels with the
            // sum so a quick stop/restart cannot rescale an in-flight block.
            sum_d       = acc_q + sample_s;
            sum_k_d     = k_q;
            sum_valid_d = 1'b1;
            acc_d       = '0;
            count_d     = '0;
          end else begin
            acc_d   = acc_q + sample_s;
            count_d = count_q + CNT_W'(1);
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Output register and handshake.
  always_comb begin
    out_data_d    = out_data_q;
    out_valid_d   = out_valid_q;
    overrun_d     = overrun_q;
    frame_count_d = frame_count_q;

    if (run_start) overrun_d = 1'b0;

    if (scl_valid) begin
      out_data_d    = scl_data;
      out_valid_d   = 1'b1;
      frame_count_d = frame_count_q + 16'd1;
      if (out_valid_q && !OutReady) overrun_d = 1'b1;
    end else if (out_valid_q && OutReady) begin
      out_valid_d = 1'b0;
    end
  end

  decim_scaler #(
    .ACC_W(ACC_W)
  ) u_scaler (
    .clk      (Fg_CLK),
    .rst      (Fg_RESET),
    .in_sum   (sum_q),
    .in_k     (sum_k_q),
    .in_valid (sum_valid_q),
    .out_data (scl_data),
    .out_valid(scl_valid)
  );

  always_ff @(posedge Fg_CLK or posedge Fg_RESET) begin
    if (Fg_RESET) begin
      state_q       <= IDLE;
      acc_q         <= '0;
      count_q       <= '0;
      r_q           <= R_1;
      k_q           <= K_1;
      sum_q         <= '0;
      sum_k_q       <= '0;
      sum_valid_q   <= 1'b0;
      out_data_q    <= '0;
      out_valid_q   <= 1'b0;
      overrun_q     <= 1'b0;
      frame_count_q <= '0;
    end else begin
      // NOTE: non-blocking assignments so every flop samples pre-edge values.
      state_q       <= state_d;
      acc_q         <= acc_d;
      count_q       <= count_d;
      r_q           <= r_d;
      k_q           <= k_d;
      sum_q         <= sum_d;
      sum_k_q       <= sum_k_d;
      sum_valid_q   <= sum_valid_d;
      out_data_q    <= out_data_d;
      out_valid_q   <= out_valid_d;
      overrun_q     <= overrun_d;
      frame_count_q <= frame_count_d;
    end
  end

  assign OutData    = out_data_q;
  assign OutValid   = out_valid_q;
  assign Overrun    = overrun_q;
  assign FrameCount = frame_count_q;
  assign Busy       = (state_q == ACCUM);

endmodule

// File: doc/adc_decimator.md
# adc_decimator

Receive-side counterpart of the DAC interpolator: accepts 12-bit offset-binary ADC samples, converts them to two's complement, and averages blocks of R = 1/10/100/1000 samples selected by `Mode`. Each block average is scaled with the same Q29 reciprocal constants the transmit path uses. Sits between the ADC capture logic and the impedance DSP/readout, and emits one 32-bit signed average per block over a valid/ready handshake.

## Interface
- `DATA_W`, 12: ADC sample width (offset binary).
- `ACC_W`, 32: accumulator and output width (signed).
- `Fg_CLK`  in  1  sole clock, rising edge.
- `Fg_RESET`  in  1  reset, asynchronous and active-high.
- `AdcData`  in  12  ADC sample, offset binary (0x800 = zero).
- `AdcValid`  in  1  AdcData is valid this cycle.
- `Mode`  in  3  ratio select: 0→R=1, 1→10, 2→100, 3→1000, 4–7→R=1.
- `Run`  in  1  level; 1 = decimate continuously, 0 = stop.
- `OutData`  out  32  signed block average.
- `OutValid`  out  1  OutData holds an unconsumed result.
- `OutReady`  in  1  consumer accepts OutData.
- `Busy`  out  1  FSM in ACCUM.
- `Overrun`  out  1  sticky: an unconsumed result was overwritten.
- `FrameCount`  out  16  completed blocks, wraps 0xFFFF→0.

## Operation
- Sample conversion: s = signed({~AdcData[11], AdcData[10:0]}), sign-extended to 32 bits.
- Scale constant K (unsigned, 32 bits) per ratio: R=1→536870912 (2^29), 10→53687091, 100→5368709, 1000→536871.
- FSM, two states:
  - IDLE: AdcValid is ignored. On Run=1, latch R/K from Mode, clear acc and count, clear Overrun, go to ACCUM.
  - ACCUM: each AdcValid does acc += s and count++. When a sample is the R-th of its block, capture the final sum (including that sample) into the pipeline, then reset acc=0 and count=0 on the same edge and stay in ACCUM. A gap-free stream loses no samples.
  - ACCUM with Run=0: discard the partial block and go to IDLE. The edge that sees Run=0 does not accept AdcValid. Blocks already in the pipeline still complete.
- Mode changes during ACCUM are ignored until the next IDLE→ACCUM transition.
- Scaling: p = signed(sum) × signed({1'b0,K}), 64 bits. Round half-up by adding 2^28. Result = p[60:29]. The maximum |sum| is 2,048,000, so there is no overflow.
- Output handshake:
  - A new result loads OutData, sets OutValid=1, and increments FrameCount.
  - OutValid drops on an edge with OutValid=1 and OutReady=1 when no new result loads on that edge.
  - New result arrives with OutValid=1 and OutReady=0: OutData is overwritten and Overrun is set to 1.
  - New result arrives with OutReady=1: no overrun; OutValid stays 1.
- Busy = (state == ACCUM).

## Timing
- Reset values: state IDLE, acc 0, count 0, pipeline valids 0, OutData 0, OutValid 0, Overrun 0, FrameCount 0, Busy 0.
- Run sampled 1 at edge e: Busy=1 after e. The first sample is accepted at edge e+1 or later.
- Final sample of a block accepted at edge k:
  - Sum register loads at k.
  - Rounded product registers at k+1.
  - OutData/OutValid/FrameCount update at k+2.
- Pipeline throughput is one result per cycle, so R=1 with AdcValid held high gives OutValid on every cycle.
- Fg_RESET mid-block: all state clears immediately. The partial block and in-flight results are lost.
- Simultaneous Run falling and R-th sample: Run wins, the sample is not accepted, and no output is produced.

## Structure
- Package `decim_pkg` holds:
  - the FSM state enum (IDLE, ACCUM);
  - the R and K constant tables;
  - the Q29 shift (29) and rounding constant (2^28);
  - a function mapping Mode to {R, K}.
- Sub-module `decim_scaler`: a single-stage registered signed 32×33 multiply with round and slice, plus its valid bit. The top level holds the FSM, accumulator, counter, output register and handshake.

## Test plan
- Mode=1, Run=1, 10 samples of 0x900 back-to-back, OutReady=1 → one OutValid pulse two cycles after the 10th sample, OutData=256, FrameCount=1.
- Mode=1, 10 samples of 0x700 → OutData=−256 (0xFFFFFF00). Mode=3, 1000×0xFFF → 2047; 1000×0x000 → −2048.
- Mode=0, AdcValid=1 for 5 cycles with 0x800,0x801,0x7FF,0xFFF,0x000 → outputs 0, 1, −1, 2047, −2048 on 5 consecutive cycles.
- Mode=1, OutReady=0, 20 samples → after the first result OutValid=1 and Overrun=0. After the second, OutData holds block 2 and Overrun=1. Pulsing OutReady clears OutValid; Overrun stays 1 until Run toggles through IDLE.
- Mode=2, drop Run after 50 samples → Busy=0 next cycle and no output. Re-raise Run with Mode=1 and send 10 samples → a single result with R=10.
- Assert Fg_RESET during sample 5 of a Mode=1 block → all outputs return to reset values asynchronously, with no OutValid after reset is released.
